// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Host index width; a single-bit index is kept even for tiny configurations.
  function automatic int unsigned HostIdW(input int unsigned nr_hosts);
    return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned CntW(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Ibex-style req/gnt/rvalid bus, NrPorts lanes wide. Used once for the host
// side (one lane per host) and once for the single downstream device port.
interface bus_rr_arbiter_if #(
  parameter int unsigned NrPorts   = 1,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [NrPorts-1:0]                  req;
  logic [NrPorts-1:0]                  gnt;
  logic [NrPorts-1:0][AddrWidth-1:0]   addr;
  logic [NrPorts-1:0]                  we;
  logic [NrPorts-1:0][DataWidth/8-1:0] be;
  logic [NrPorts-1:0][DataWidth-1:0]   wdata;
  logic [NrPorts-1:0]                  rvalid;
  logic [NrPorts-1:0][DataWidth-1:0]   rdata;
  logic [NrPorts-1:0]                  err;

  // Side that issues requests.
  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  // Side that accepts requests and returns responses.
  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/bus_rr_arbiter_id_fifo.sv
// Response-routing FIFO: remembers which host issued each accepted request.
// Read data is the head entry, presented combinationally.
module bus_arb_id_fifo
  import bus_arb_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [Width-1:0]         i_wdata,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [CntW(Depth)-1:0]   o_count
);

  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWd = CntW(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntWd-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CntWd'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Overflow/underflow attempts are dropped rather than corrupting state.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap at Depth (not a power of two in general); count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntWd'(w_push) - CntWd'(w_pop);
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one downstream req/gnt/rvalid port between
// NrHosts hosts, with an ID FIFO routing each response to its issuer.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no stalled request; pick first requester from rr pointer
//   ST_LOCKED  | request presented without grant; hold lock_idx stable
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  bus_rr_arbiter_if.slave                  host_if,
  bus_rr_arbiter_if.master                 dev_if,
  output logic [CntW(MaxOutstanding)-1:0]  outstanding_o,
  output logic                             unexp_rsp_o
);

  localparam int unsigned IdW      = HostIdW(NrHosts);
  localparam int unsigned CntWidth = CntW(MaxOutstanding);

  localparam logic [0:0] ST_IDLE   = ArbIdle;
  localparam logic [0:0] ST_LOCKED = ArbLocked;

  logic [0:0]     r_state;
  logic [IdW-1:0] r_lock_idx;
  logic [IdW-1:0] r_rr_ptr;
  logic           r_unexp;

  logic [IdW-1:0]      w_cand;
  logic [IdW-1:0]      w_rr_sel;
  logic [IdW-1:0]      w_sel;
  logic [IdW-1:0]      w_head;
  logic                w_req_present;
  logic                w_dev_req;
  logic                w_hs;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CntWidth-1:0] w_count;

  // Rotating-priority search: walk offsets from high to low so the nearest
  // requester at or after rr_ptr is the last (winning) assignment.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_cand   = '0;
    for (int k = NrHosts - 1; k >= 0; k--) begin
      w_cand = IdW'((int'(r_rr_ptr) + k) % NrHosts);
      if (host_if.req[w_cand]) w_rr_sel = w_cand;
    end
  end

  assign w_sel         = (r_state == ST_LOCKED) ? r_lock_idx : w_rr_sel;
  assign w_req_present = (r_state == ST_LOCKED) ? host_if.req[r_lock_idx] : |host_if.req;

  // Reset gates every control output so nothing leaks during the reset cycle.
  assign w_dev_req = rst_ni & w_req_present & ~w_full;
  assign w_hs      = w_dev_req & dev_if.gnt[0];
  assign w_pop     = rst_ni & dev_if.rvalid[0] & ~w_empty;

  assign dev_if.req[0]   = w_dev_req;
  assign dev_if.addr[0]  = host_if.addr[w_sel];
  assign dev_if.we[0]    = host_if.we[w_sel];
  assign dev_if.be[0]    = host_if.be[w_sel];
  assign dev_if.wdata[0] = host_if.wdata[w_sel];

  assign outstanding_o = rst_ni ? w_count : '0;
  assign unexp_rsp_o   = rst_ni & r_unexp;

  // Grant goes to the selected host; response goes to the FIFO head, data broadcast.
  always_comb begin
    host_if.gnt    = '0;
    host_if.rvalid = '0;
    host_if.err    = '0;
    for (int i = 0; i < NrHosts; i++) host_if.rdata[i] = dev_if.rdata[0];
    if (w_hs) host_if.gnt[w_sel] = 1'b1;
    if (w_pop) begin
      host_if.rvalid[w_head] = 1'b1;
      host_if.err[w_head]    = dev_if.err[0];
    end
  end

  // Lock a stalled selection until granted; advance rr pointer past each winner.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
    end else if (w_hs) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= (w_sel == IdW'(NrHosts - 1)) ? '0 : w_sel + IdW'(1);
    end else if (w_dev_req) begin
      r_state    <= ST_LOCKED;
      r_lock_idx <= w_sel;
    end
  end

  // Sticky flag for responses arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_unexp <= 1'b0;
    end else if (dev_if.rvalid[0] & w_empty) begin
      r_unexp <= 1'b1;
    end
  end

  bus_arb_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_hs),
    .i_pop   (w_pop),
    .i_wdata (w_sel),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: directed scenarios then random traffic.
module tb_bus_rr_arbiter;

  localparam int NH = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [1:0] outstanding_o;
  logic       unexp_rsp_o;

  bus_rr_arbiter_if #(.NrPorts(NH), .AddrWidth(AW), .DataWidth(DW)) host_bus ();
  bus_rr_arbiter_if #(.NrPorts(1),  .AddrWidth(AW), .DataWidth(DW)) dev_bus ();

  bus_rr_arbiter #(
    .NrHosts(NH), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .host_if       (host_bus),
    .dev_if        (dev_bus),
    .outstanding_o (outstanding_o),
    .unexp_rsp_o   (unexp_rsp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            host;
    logic [AW-1:0] addr;
  } gnt_exp_t;

  typedef struct {
    int            host;
    logic          err;
    logic [DW-1:0] data;
  } rsp_exp_t;

  int n_vec = 0;
  int n_err = 0;

  gnt_exp_t exp_gnt[$];
  rsp_exp_t exp_rsp[$];
  gnt_exp_t mon_g;
  rsp_exp_t mon_r;

  // Reference model: queue of issuing hosts, rotating pointer, stalled host.
  int      m_rr = 0;
  bit      m_locked = 0;
  int      m_lock_h = 0;
  int      m_ids[$];
  bit      m_unexp = 0;
  logic [NH-1:0] last_granted;
  logic [NH-1:0] pend = '0;

  logic [AW-1:0]   h_addr [NH];
  logic            h_we   [NH];
  logic [DW/8-1:0] h_be   [NH];
  logic [DW-1:0]   h_wdata[NH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: called at a negedge, drives inputs, predicts, returns at next negedge.
  task automatic step(input logic [NH-1:0] req, input logic rst, input logic g,
                      input logic rv, input logic er, input logic [DW-1:0] rd);
    int  n;
    int  sel;
    bit  any;
    bit  exp_req;
    bit  hs;
    rst_ni = rst;
    host_bus.req = req;
    for (int h = 0; h < NH; h++) begin
      host_bus.addr[h]  = h_addr[h];
      host_bus.we[h]    = h_we[h];
      host_bus.be[h]    = h_be[h];
      host_bus.wdata[h] = h_wdata[h];
    end
    dev_bus.gnt[0]    = g;
    dev_bus.rvalid[0] = rv;
    dev_bus.err[0]    = er;
    dev_bus.rdata[0]  = rd;
    last_granted = '0;
    #1;
    if (!rst) begin
      chk("rst_dev_req", 64'(dev_bus.req[0]), 0);
      chk("rst_gnt", 64'(host_bus.gnt), 0);
      chk("rst_rvalid", 64'(host_bus.rvalid), 0);
      chk("rst_outstanding", 64'(outstanding_o), 0);
      chk("rst_unexp", 64'(unexp_rsp_o), 0);
      m_ids.delete();
      m_rr = 0;
      m_locked = 0;
      m_unexp = 0;
    end else begin
      assert (!(m_locked && !req[m_lock_h]))
        else $error("FAIL lock_hold: stalled host %0d dropped req", m_lock_h);
      n = m_ids.size();
      sel = -1;
      if (m_locked) begin
        sel = m_lock_h;
        any = req[sel];
      end else begin
        for (int k = 0; k < NH; k++) begin
          if (sel < 0 && req[(m_rr + k) % NH]) sel = (m_rr + k) % NH;
        end
        any = (sel >= 0);
      end
      exp_req = any && (n < MO);
      hs = exp_req && g;
      chk("dev_req", 64'(dev_bus.req[0]), 64'(exp_req));
      chk("outstanding", 64'(outstanding_o), 64'(n));
      chk("unexp", 64'(unexp_rsp_o), 64'(m_unexp));
      if (exp_req) begin
        chk("dev_addr", 64'(dev_bus.addr[0]), 64'(h_addr[sel]));
        chk("dev_wfields", 64'({dev_bus.we[0], dev_bus.be[0], dev_bus.wdata[0]}),
            64'({h_we[sel], h_be[sel], h_wdata[sel]}));
      end
      if (rv) begin
        if (n > 0) begin
          exp_rsp.push_back('{host: m_ids[0], err: er, data: rd});
          void'(m_ids.pop_front());
        end else begin
          m_unexp = 1;
        end
      end
      if (hs) begin
        exp_gnt.push_back('{host: sel, addr: h_addr[sel]});
        m_ids.push_back(sel);
        m_rr = (sel + 1) % NH;
        m_locked = 0;
        last_granted[sel] = 1'b1;
      end else if (exp_req) begin
        m_locked = 1;
        m_lock_h = sel;
      end
    end
    @(negedge clk_i);
  endtask

  // Monitor: whenever the DUT presents a grant or response, pop and compare.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (|host_bus.gnt) begin
        chk("gnt_onehot", 64'($countones(host_bus.gnt)), 1);
        if (exp_gnt.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL gnt_extra: actual gnt=%b required none (t=%0t)", host_bus.gnt, $time);
        end else begin
          mon_g = exp_gnt.pop_front();
          chk("gnt_host", 64'(host_bus.gnt), 64'(1) << mon_g.host);
          chk("gnt_addr", 64'(dev_bus.addr[0]), 64'(mon_g.addr));
        end
      end
      if (|host_bus.rvalid) begin
        chk("rvalid_onehot", 64'($countones(host_bus.rvalid)), 1);
        if (exp_rsp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_extra: actual rvalid=%b required none (t=%0t)", host_bus.rvalid, $time);
        end else begin
          mon_r = exp_rsp.pop_front();
          chk("rsp_host", 64'(host_bus.rvalid), 64'(1) << mon_r.host);
          chk("rsp_err", 64'(host_bus.err), 64'(mon_r.err) << mon_r.host);
          for (int h = 0; h < NH; h++) chk("rsp_data", 64'(host_bus.rdata[h]), 64'(mon_r.data));
        end
      end else begin
        chk("err_idle", 64'(host_bus.err), 0);
      end
    end
  end

  initial begin
    h_addr[0] = 32'hA000_0010; h_we[0] = 1'b1; h_be[0] = 4'hF; h_wdata[0] = 32'h1111_0000;
    h_addr[1] = 32'hB000_0020; h_we[1] = 1'b0; h_be[1] = 4'h3; h_wdata[1] = 32'h2222_0000;
    host_bus.req = '0;
    dev_bus.gnt = '0;
    dev_bus.rvalid = '0;
    dev_bus.err = '0;
    dev_bus.rdata = '0;
    @(negedge clk_i);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Back-to-back alternating grants, each answered one cycle later.
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) step(2'b11, 1'b1, 1'b1, 1'b1, 1'(k), 32'hD0 + 32'(k));
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDF);
    step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Stalled H1 holds the bus while H0 joins; H1 then H0 granted.
    step(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 32'hE1);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE0);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Full FIFO blocks requests even while popping; freed slot next cycle.
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 32'hF0);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'hF1);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF2);

    // Push and pop together at count 1.
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC0);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC1);

    // Unexpected response is sticky until reset.
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h77);
    step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h78);
    step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset with two outstanding and rr pointing at H1; restart from H0.
    step(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h55);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h56);
    step(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h57);

    // Random traffic: a host keeps its request and fields until granted.
    pend = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int h = 0; h < NH; h++) begin
        if (!pend[h] && $urandom_range(0, 99) < 55) begin
          pend[h]    = 1'b1;
          h_addr[h]  = $urandom;
          h_we[h]    = 1'($urandom);
          h_be[h]    = 4'($urandom);
          h_wdata[h] = $urandom;
        end
      end
      step(pend, 1'b1, ($urandom_range(0, 3) != 0),
           (m_ids.size() > 0) && ($urandom_range(0, 1) == 1), 1'($urandom), $urandom);
      pend &= ~last_granted;
    end

    for (int i = 0; i < MO + 2; i++)
      step(2'b00, 1'b1, 1'b0, (m_ids.size() > 0), 1'b0, $urandom);

    chk("gnt_queue_drained", 64'(exp_gnt.size()), 0);
    chk("rsp_queue_drained", 64'(exp_rsp.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
